idma_desc64_fetch_assembler: RTL and testbench

//  Fetches 256-bit desc64 descriptors from memory over a 64-bit AXI read port and feeds

---
 rtl/idma_desc64_fetch_assembler.sv | 177 +++++++++++++++++
 tb/tb_idma_desc64_fetch_assembler.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_desc64_fetch_assembler.sv
// idma_desc64_fetch_assembler
// Fetches 256-bit desc64 descriptors over a 64-bit AXI read port. Each accepted address
// becomes one 4-beat INCR read, and the beats are assembled into a descriptor_t. Finished
// descriptors are queued in an in-order FIFO. Credits cap reads in flight plus FIFO
// occupancy at BufferDepth, so every read has a FIFO slot reserved and R never stalls.
// Optional feature macro: IDMA_DESC64_FETCH_ERR_EN (drop descriptors with a bus error).
module idma_desc64_fetch_assembler #(
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned BufferDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] desc_addr_i,
  input  logic                 desc_addr_valid_i,
  output logic                 desc_addr_ready_o,
  output logic [AddrWidth-1:0] ar_addr_o,
  output logic [7:0]           ar_len_o,
  output logic                 ar_valid_o,
  input  logic                 ar_ready_i,
  input  logic [63:0]          r_data_i,
  input  logic [1:0]           r_resp_i,
  input  logic                 r_valid_i,
  output logic                 r_ready_o,
  output logic [255:0]         descriptor_o,
  output logic                 desc_valid_o,
  input  logic                 desc_ready_i,
  output logic                 busy_o,
  output logic                 err_o
);

  typedef struct packed {
    logic [63:0] dest_addr;
    logic [63:0] src_addr;
    logic [63:0] next;
    logic [31:0] flags;
    logic [31:0] length;
  } descriptor_t;

  localparam int unsigned PtrW = (BufferDepth > 1) ? $clog2(BufferDepth) : 1;
  localparam int unsigned CntW = $clog2(BufferDepth + 1);
  localparam logic [CntW-1:0] Depth   = CntW'(BufferDepth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(BufferDepth - 1);

  typedef enum logic [0:0] {ArIdle, ArReq} ar_state_e;

  ar_state_e            ar_state_q, ar_state_d;
  logic [AddrWidth-1:0] ar_addr_q, ar_addr_d;
  logic [CntW-1:0]      inflight_q, inflight_d;  // reads accepted but not finished (AR pending too)
  logic [CntW-1:0]      count_q, count_d;
  logic [CntW-1:0]      credits;
  logic [1:0]           beat_q, beat_d;
  logic [191:0]         stage_q, stage_d;        // beats 0..2; beat 3 goes straight to the FIFO
  logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  descriptor_t          mem_q [BufferDepth];

  logic addr_hs, r_hs, last_hs, push, pop, drop;

  assign credits           = Depth - count_q - inflight_q;
  assign desc_addr_ready_o = (ar_state_q == ArIdle) && (credits != '0);
  assign addr_hs           = desc_addr_valid_i && desc_addr_ready_o;
  assign ar_valid_o        = (ar_state_q == ArReq);
  assign ar_addr_o         = ar_addr_q;
  assign ar_len_o          = 8'd3;
  // Stray beats with nothing in flight are left unconsumed.
  assign r_ready_o         = (inflight_q != '0);
  assign r_hs              = r_valid_i && r_ready_o;
  assign last_hs           = r_hs && (beat_q == 2'd3);
  assign desc_valid_o      = (count_q != '0);
  assign pop               = desc_valid_o && desc_ready_i;
  assign push              = last_hs && !drop;
  assign descriptor_o      = desc_valid_o ? mem_q[rptr_q] : '0;
  assign busy_o            = (inflight_q != '0) || (count_q != '0);

`ifdef IDMA_DESC64_FETCH_ERR_EN
  logic err_q, err_d, err_pulse_q, err_pulse_d;
  logic unused_resp0;
  assign unused_resp0 = r_resp_i[0];
  // The error is sticky across the four beats; include the current beat in the decision.
  assign drop  = last_hs && (err_q || r_resp_i[1]);
  assign err_o = err_pulse_q;

  // Next-state of the per-descriptor error flag and the one-cycle drop pulse.
  always_comb begin
    err_d       = err_q;
    err_pulse_d = drop;
    if (last_hs) begin
      err_d = 1'b0;
    end else if (r_hs && r_resp_i[1]) begin
      err_d = 1'b1;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q       <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      err_q       <= err_d;
      err_pulse_q <= err_pulse_d;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ^r_resp_i;
  assign drop        = 1'b0;
  assign err_o       = 1'b0;
`endif

  // AR channel FSM: latch the address on handshake, hold it until AR is accepted.
  always_comb begin
    ar_state_d = ar_state_q;
    ar_addr_d  = ar_addr_q;
    unique case (ar_state_q)
      ArIdle: begin
        if (addr_hs) begin
          ar_state_d = ArReq;
          ar_addr_d  = desc_addr_i;
        end
      end
      ArReq: begin
        if (ar_ready_i) ar_state_d = ArIdle;
      end
      default: ar_state_d = ArIdle;
    endcase
  end

  // Bookkeeping: in-flight reads, FIFO occupancy/pointers, beat counter and staging.
  always_comb begin
    inflight_d = inflight_q + CntW'(addr_hs) - CntW'(last_hs);
    count_d    = count_q + CntW'(push) - CntW'(pop);
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    beat_d     = beat_q;
    stage_d    = stage_q;
    if (push) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
    if (pop)  rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);
    if (r_hs) begin
      beat_d = beat_q + 2'd1;
      case (beat_q)
        2'd0:    stage_d[63:0]    = r_data_i;
        2'd1:    stage_d[127:64]  = r_data_i;
        2'd2:    stage_d[191:128] = r_data_i;
        default: ;
      endcase
    end
  end

  // Control and staging registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ar_state_q <= ArIdle;
      ar_addr_q  <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      beat_q     <= '0;
      stage_q    <= '0;
    end else begin
      ar_state_q <= ar_state_d;
      ar_addr_q  <= ar_addr_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      beat_q     <= beat_d;
      stage_q    <= stage_d;
    end
  end

  // FIFO storage; contents are only observed while occupancy is non-zero.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= {r_data_i, stage_q};
  end

endmodule

// File: tb/tb_idma_desc64_fetch_assembler.sv
// Self-checking bench for idma_desc64_fetch_assembler (BufferDepth=2). A behavioural
// memory holds each descriptor as one 256-bit word; the expected output stream is the
// list of accepted addresses mapped through that memory (minus errored ones when
// IDMA_DESC64_FETCH_ERR_EN is defined).
module tb_idma_desc64_fetch_assembler;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic [63:0]  desc_addr_i = '0;
  logic         desc_addr_valid_i = 1'b0;
  logic         desc_addr_ready_o;
  logic [63:0]  ar_addr_o;
  logic [7:0]   ar_len_o;
  logic         ar_valid_o;
  logic         ar_ready_i = 1'b0;
  logic [63:0]  r_data_i = '0;
  logic [1:0]   r_resp_i = '0;
  logic         r_valid_i = 1'b0;
  logic         r_ready_o;
  logic [255:0] descriptor_o;
  logic         desc_valid_o;
  logic         desc_ready_i = 1'b0;
  logic         busy_o;
  logic         err_o;

  idma_desc64_fetch_assembler #(
    .AddrWidth  (64),
    .BufferDepth(2)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .desc_addr_i      (desc_addr_i),
    .desc_addr_valid_i(desc_addr_valid_i),
    .desc_addr_ready_o(desc_addr_ready_o),
    .ar_addr_o        (ar_addr_o),
    .ar_len_o         (ar_len_o),
    .ar_valid_o       (ar_valid_o),
    .ar_ready_i       (ar_ready_i),
    .r_data_i         (r_data_i),
    .r_resp_i         (r_resp_i),
    .r_valid_i        (r_valid_i),
    .r_ready_o        (r_ready_o),
    .descriptor_o     (descriptor_o),
    .desc_valid_o     (desc_valid_o),
    .desc_ready_i     (desc_ready_i),
    .busy_o           (busy_o),
    .err_o            (err_o)
  );

  int errors = 0;
  int checks = 0;
  int err_cnt = 0;
  bit auto_r = 1'b0;
  bit rand_ar = 1'b0;

  logic [255:0] mem_d [logic [63:0]];
  int           eb    [logic [63:0]];   // beat index carrying a bus error
  logic [63:0]  ar_log[$], exp_ar[$], pend_q[$];
  logic [255:0] out_q[$], exp_q[$];

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  task automatic chk1(input string tag, input logic o, input logic e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic chkw(input string tag, input logic [255:0] o, input logic [255:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chki(input string tag, input int o, input int e);
    checks++;
    assert (o == e) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic void accepted(input logic [63:0] a);
    exp_ar.push_back(a);
`ifdef IDMA_DESC64_FETCH_ERR_EN
    if (!(eb.exists(a) && eb[a] < 4)) exp_q.push_back(mem_d[a]);
`else
    exp_q.push_back(mem_d[a]);
`endif
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Offer one address for at most maxc cycles.
  task automatic offer(input logic [63:0] a, input int maxc, output bit took);
    took = 1'b0;
    desc_addr_i = a;
    desc_addr_valid_i = 1'b1;
    for (int n = 0; n < maxc && !took; n++) begin
      @(posedge clk_i);
      took = desc_addr_ready_o;
      #1;
    end
    desc_addr_valid_i = 1'b0;
    if (took) accepted(a);
  endtask

  // Drive one R beat of descriptor a until it is accepted.
  task automatic send_beat(input logic [63:0] a, input int k);
    logic [255:0] d;
    int e;
    bit hs;
    d  = mem_d.exists(a) ? mem_d[a] : '0;
    e  = eb.exists(a) ? eb[a] : 4;
    hs = 1'b0;
    r_valid_i = 1'b1;
    r_data_i  = d[64*k +: 64];
    r_resp_i  = (e == k) ? 2'b10 : 2'b00;
    for (int n = 0; n < 50 && !hs; n++) begin
      @(posedge clk_i);
      hs = r_ready_o;
      #1;
    end
    r_valid_i = 1'b0;
    r_resp_i  = 2'b00;
    if (!hs) chk1("r_beat_accepted", 1'b0, 1'b1);
  endtask

  task automatic wait_out(input string tag, input int n);
    for (int i = 0; i < 300 && out_q.size() < n; i++) step();
    chki(tag, out_q.size(), n);
  endtask

  task automatic compare_desc(input string tag);
    chki({tag, "_desc_count"}, out_q.size(), exp_q.size());
    while (out_q.size() != 0 && exp_q.size() != 0)
      chkw({tag, "_desc"}, out_q.pop_front(), exp_q.pop_front());
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic compare_ar(input string tag);
    chki({tag, "_ar_count"}, ar_log.size(), exp_ar.size());
    while (ar_log.size() != 0 && exp_ar.size() != 0)
      chkw({tag, "_ar_addr"}, 256'(ar_log.pop_front()), 256'(exp_ar.pop_front()));
    ar_log.delete();
    exp_ar.delete();
  endtask

  // Channel monitors: log handshakes, check AR/descriptor hold while stalled, count err_o.
  initial begin
    bit           ar_hold, d_hold;
    logic [63:0]  ar_prev;
    logic [255:0] d_prev;
    ar_hold = 1'b0;
    d_hold  = 1'b0;
    forever begin
      @(posedge clk_i);
      if (!rst_ni) begin
        ar_hold = 1'b0;
        d_hold  = 1'b0;
      end else begin
        if (ar_hold) begin
          chk1("ar_valid_held", ar_valid_o, 1'b1);
          chkw("ar_addr_held", 256'(ar_addr_o), 256'(ar_prev));
        end
        if (d_hold) begin
          chk1("desc_valid_held", desc_valid_o, 1'b1);
          chkw("descriptor_held", descriptor_o, d_prev);
        end
        if (ar_valid_o && ar_ready_i) begin
          chkw("ar_len", 256'(ar_len_o), 256'(8'd3));
          ar_log.push_back(ar_addr_o);
          pend_q.push_back(ar_addr_o);
        end
        if (desc_valid_o && desc_ready_i) out_q.push_back(descriptor_o);
        if (err_o) err_cnt++;
        ar_hold = ar_valid_o && !ar_ready_i;
        ar_prev = ar_addr_o;
        d_hold  = desc_valid_o && !desc_ready_i;
        d_prev  = descriptor_o;
      end
    end
  end

  // Automatic R responder: serves accepted reads in order.
  initial forever begin
    logic [63:0] a;
    step();
    if (auto_r && rst_ni && pend_q.size() != 0) begin
      a = pend_q.pop_front();
      for (int k = 0; k < 4; k++) send_beat(a, k);
    end
  end

  // Random AR backpressure.
  initial forever begin
    step();
    if (rand_ar) ar_ready_i = 1'($urandom_range(0, 1));
  end

  initial begin
    bit took;
    logic [63:0] a, b1, b2;

    // Reset values
    repeat (3) step();
    chk1("rst_ar_valid", ar_valid_o, 1'b0);
    chk1("rst_desc_valid", desc_valid_o, 1'b0);
    chk1("rst_err", err_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_r_ready", r_ready_o, 1'b0);
    chk1("rst_addr_ready", desc_addr_ready_o, 1'b1);
    chkw("rst_descriptor", descriptor_o, '0);
    rst_ni = 1'b1;
    step();

    // Stray R beats with nothing in flight must not be consumed
    r_valid_i = 1'b1;
    r_data_i  = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    chk1("stray_r_ready", r_ready_o, 1'b0);
    step();
    r_valid_i = 1'b0;

    // Single fetch
    mem_d[64'h1000] = {64'h4000, 64'h3000, 64'h2000, 64'h00AA_0001_0000_0040};
    ar_ready_i = 1'b1;
    auto_r = 1'b1;
    offer(64'h1000, 10, took);
    chk1("single_took", took, 1'b1);
    chk1("single_ar_valid", ar_valid_o, 1'b1);
    chkw("single_ar_addr", 256'(ar_addr_o), 256'(64'h1000));
    chkw("single_ar_len", 256'(ar_len_o), 256'(8'd3));
    chk1("single_addr_ready_req", desc_addr_ready_o, 1'b0);
    step();
    chk1("single_ar_done", ar_valid_o, 1'b0);
    chk1("single_addr_ready_b2b", desc_addr_ready_o, 1'b1);
    chk1("single_busy", busy_o, 1'b1);
    for (int i = 0; i < 50 && !desc_valid_o; i++) step();
    chk1("single_valid", desc_valid_o, 1'b1);
    chkw("single_length", 256'(descriptor_o[31:0]), 256'(32'h40));
    chkw("single_flags", 256'(descriptor_o[63:32]), 256'(32'h00AA_0001));
    chkw("single_next", 256'(descriptor_o[127:64]), 256'(64'h2000));
    chkw("single_src", 256'(descriptor_o[191:128]), 256'(64'h3000));
    chkw("single_dst", 256'(descriptor_o[255:192]), 256'(64'h4000));
    desc_ready_i = 1'b1;
    step();
    desc_ready_i = 1'b0;
    compare_desc("single");
    compare_ar("single");
    chk1("single_idle", busy_o, 1'b0);

    // Credit limit: third address waits for a pop
    for (int i = 0; i < 3; i++) mem_d[64'h2_0000 + 64'(32 * i)] = rand256();
    offer(64'h2_0000, 10, took);
    chk1("credit_took0", took, 1'b1);
    offer(64'h2_0020, 10, took);
    chk1("credit_took1", took, 1'b1);
    offer(64'h2_0040, 30, took);
    chk1("credit_blocked", took, 1'b0);
    chki("credit_ar_count", ar_log.size(), 2);
    chk1("credit_full_valid", desc_valid_o, 1'b1);
    chk1("credit_full_ready", desc_addr_ready_o, 1'b0);
    desc_ready_i = 1'b1;
    step();
    desc_ready_i = 1'b0;
    offer(64'h2_0040, 3, took);
    chk1("credit_after_pop", took, 1'b1);
    desc_ready_i = 1'b1;
    wait_out("credit_drain", 3);
    desc_ready_i = 1'b0;
    compare_desc("credit");
    compare_ar("credit");

    // Simultaneous pop and beat-3 push
    auto_r = 1'b0;
    b1 = 64'h3_0000;
    b2 = 64'h3_0020;
    mem_d[b1] = rand256();
    mem_d[b2] = rand256();
    offer(b1, 10, took);
    step();
    a = pend_q.pop_front();
    for (int k = 0; k < 4; k++) send_beat(a, k);
    offer(b2, 10, took);
    step();
    a = pend_q.pop_front();
    for (int k = 0; k < 3; k++) send_beat(a, k);
    desc_ready_i = 1'b1;
    send_beat(a, 3);
    desc_ready_i = 1'b0;
    chki("simul_popped", out_q.size(), 1);
    chk1("simul_valid", desc_valid_o, 1'b1);
    chkw("simul_head", descriptor_o, mem_d[b2]);
    chk1("simul_addr_ready", desc_addr_ready_o, 1'b1);
    desc_ready_i = 1'b1;
    step();
    desc_ready_i = 1'b0;
    compare_desc("simul");
    compare_ar("simul");

    // Back-to-back with random AR backpressure
    auto_r = 1'b1;
    rand_ar = 1'b1;
    desc_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 64'h4_0000 + 64'(32 * i);
      mem_d[a] = rand256();
      offer(a, 50, took);
      chk1("b2b_took", took, 1'b1);
    end
    wait_out("b2b_drain", 4);
    rand_ar = 1'b0;
    step();
    ar_ready_i = 1'b1;
    compare_desc("b2b");
    compare_ar("b2b");

    // Bus error on beat 2, then a clean fetch
    err_cnt = 0;
    mem_d[64'h5_0000] = rand256();
    eb[64'h5_0000] = 2;
    mem_d[64'h5_0020] = rand256();
    offer(64'h5_0000, 10, took);
    offer(64'h5_0020, 10, took);
    for (int i = 0; i < 200 && busy_o; i++) step();
    repeat (2) step();
    chk1("err_idle", busy_o, 1'b0);
    chk1("err_credits_back", desc_addr_ready_o, 1'b1);
    compare_desc("err");
    compare_ar("err");
`ifdef IDMA_DESC64_FETCH_ERR_EN
    chki("err_pulses", err_cnt, 1);
`else
    chki("err_pulses", err_cnt, 0);
`endif

    // Reset after beat 1, then a fresh fetch
    auto_r = 1'b0;
    desc_ready_i = 1'b0;
    mem_d[64'h6_0000] = rand256();
    offer(64'h6_0000, 10, took);
    step();
    a = pend_q.pop_front();
    send_beat(a, 0);
    send_beat(a, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk1("midrst_ar_valid", ar_valid_o, 1'b0);
    chk1("midrst_r_ready", r_ready_o, 1'b0);
    chk1("midrst_busy", busy_o, 1'b0);
    chk1("midrst_desc_valid", desc_valid_o, 1'b0);
    chk1("midrst_err", err_o, 1'b0);
    chkw("midrst_descriptor", descriptor_o, '0);
    step();
    rst_ni = 1'b1;
    pend_q.delete();
    exp_q.delete();
    compare_ar("midrst");
    auto_r = 1'b1;
    desc_ready_i = 1'b1;
    mem_d[64'h7_0000] = rand256();
    offer(64'h7_0000, 10, took);
    wait_out("post_rst_out", 1);
    compare_desc("post_rst");
    compare_ar("post_rst");
    repeat (2) step();
    chk1("post_rst_idle", busy_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
